hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//  Parametrised hazard unit for the 5-stage RV32I pipeline (PC/IF/ID/EX/MEM/WB).
//  Detects RAW hazards on the ID instruction, issues stage stall/flush controls and
//  selects operand forwarding (FWD_EN=1). Prioritises memory wait, branch flush and
//  data stalls, with a stall watchdog and saturating perf counters.
// PARAMETERS
//  FWD_EN        0   0: stall on any RAW vs EX/MEM/WB; 1: forward, stall only load-use
//  CNT_W         32  width of perf counters o_stall_cnt / o_flush_cnt
//  STALL_TIMEOUT 64  consecutive stall cycles before o_deadlock sets (>=4)
// PORTS
//  i_clk         in   1   clock, all state on rising edge
//  i_reset       in   1   synchronous reset, active-low
//  instr_id/ex/mem/wb in 32 instruction word held in each stage register
//  rd_wren_ex/mem/wb  in 1  stage instruction writes rd
//  mem_rd_ex     in   1   EX instruction is a load
//  pc_sel_ex     in   1   taken branch/jump resolved in EX
//  i_mem_stall   in   1   data memory not ready; freeze whole pipe
//  i_reset_pc/if/id/ex/mem out 1 stage reset, active-low (0 = flush stage to bubble)
//  i_enable_pc/if/id/ex/mem out 1 stage enable (0 = hold)
//  o_fwd_a_sel   out  2   rs1 source: 00 regfile,01 EX,10 MEM,11 WB producer
//  o_fwd_b_sel   out  2   rs2 source, same encoding
//  o_state       out  2   FSM state: 00 RUN,01 STALL,10 FLUSH,11 MEM_WAIT
//  o_stall_cnt   out  CNT_W  cycles with data stall asserted, saturating
//  o_flush_cnt   out  CNT_W  taken-branch flushes, saturating
//  o_deadlock    out  1   sticky: stall run reached STALL_TIMEOUT
//  data_hazard_debug out 1 raw (unprioritised) data-hazard term
// BEHAVIOUR
//  Decode: rs1 used unless opcode LUI/AUIPC/JAL; rs2 used for R/S/B only; rd==x0 never hazards.
//  Hazard FWD_EN=0: match vs any of EX/MEM/WB with rd_wren. FWD_EN=1: match vs EX with
//   mem_rd_ex=1 only. Forward sel (FWD_EN=1): youngest match wins EX>MEM>WB; sels 00 if FWD_EN=0.
//  Controls combinational (Mealy) on inputs + state; default all enables 1, resets = i_reset.
//  Priority per cycle: i_reset=0 > i_mem_stall > pc_sel_ex > data hazard.
//   mem_stall: all enables 0, no resets; no counter increments.
//   flush: i_reset_if=0, i_reset_id=0, enables 1; data hazard ignored (wrong path).
//   data stall: i_enable_pc=0, i_enable_if=0, i_reset_ex=0 (bubble into EX), ID held (enable_id=0).
//  FSM next state from the action taken: RUN/STALL/FLUSH/MEM_WAIT; FLUSH lasts 1 cycle then
//   re-evaluates; MEM_WAIT exits to RUN the cycle after i_mem_stall falls.
//  Stall run counter: +1 per data-stall cycle, cleared on any non-stall non-MEM_WAIT cycle
//   (held during MEM_WAIT); reaching STALL_TIMEOUT sets o_deadlock, cleared only by reset.
//  Perf counters saturate at all-ones, never wrap.
//  Reset (sync, any cycle incl. mid-stall): state RUN, counters 0, o_deadlock 0; during reset
//   all stage resets 0, enables 1, fwd sels 00.
// TESTING
//  FWD_EN=0: EX addi x5 (wren), ID add x6,x5,x7 -> stall 3 cycles, o_stall_cnt=3, STALL state.
//  FWD_EN=1: same stream -> no stall, o_fwd_a_sel=01; producer in WB -> 11.
//  FWD_EN=1: EX lw x5, ID add x6,x5,x5 -> exactly 1 stall cycle, then o_fwd_a/b_sel=10.
//  pc_sel_ex=1 with RAW in ID -> i_reset_if=i_reset_id=0, no stall, o_flush_cnt=1, state FLUSH.
//  i_mem_stall 5 cycles during RAW -> all enables 0, o_stall_cnt unchanged, state MEM_WAIT.
//  STALL_TIMEOUT=8, hold RAW 8 cycles -> o_deadlock=1; i_reset=0 mid-stall -> all cleared next edge.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit bundle: stage instruction words and write flags in,
// stage reset/enable controls, forwarding selects and status out.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [31:0]      instr_id;
    logic [31:0]      instr_ex;
    logic [31:0]      instr_mem;
    logic [31:0]      instr_wb;
    logic             rd_wren_ex;
    logic             rd_wren_mem;
    logic             rd_wren_wb;
    logic             mem_rd_ex;
    logic             pc_sel_ex;
    logic             i_mem_stall;
    logic             i_reset_pc;
    logic             i_reset_if;
    logic             i_reset_id;
    logic             i_reset_ex;
    logic             i_reset_mem;
    logic             i_enable_pc;
    logic             i_enable_if;
    logic             i_enable_id;
    logic             i_enable_ex;
    logic             i_enable_mem;
    logic [1:0]       o_fwd_a_sel;
    logic [1:0]       o_fwd_b_sel;
    logic [1:0]       o_state;
    logic [CNT_W-1:0] o_stall_cnt;
    logic [CNT_W-1:0] o_flush_cnt;
    logic             o_deadlock;
    logic             data_hazard_debug;

    modport master (
        output instr_id, instr_ex, instr_mem, instr_wb,
        output rd_wren_ex, rd_wren_mem, rd_wren_wb,
        output mem_rd_ex, pc_sel_ex, i_mem_stall,
        input  i_reset_pc, i_reset_if, i_reset_id, i_reset_ex, i_reset_mem,
        input  i_enable_pc, i_enable_if, i_enable_id, i_enable_ex, i_enable_mem,
        input  o_fwd_a_sel, o_fwd_b_sel, o_state,
        input  o_stall_cnt, o_flush_cnt, o_deadlock, data_hazard_debug
    );

    modport slave (
        input  instr_id, instr_ex, instr_mem, instr_wb,
        input  rd_wren_ex, rd_wren_mem, rd_wren_wb,
        input  mem_rd_ex, pc_sel_ex, i_mem_stall,
        output i_reset_pc, i_reset_if, i_reset_id, i_reset_ex, i_reset_mem,
        output i_enable_pc, i_enable_if, i_enable_id, i_enable_ex, i_enable_mem,
        output o_fwd_a_sel, o_fwd_b_sel, o_state,
        output o_stall_cnt, o_flush_cnt, o_deadlock, data_hazard_debug
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard unit for the 5-stage RV32I pipeline: RAW detection on the ID
// instruction, prioritised stall/flush controls, operand forwarding selects,
// stall watchdog and saturating performance counters.
module hazard_ctrl_unit #(
    parameter int unsigned FWD_EN        = 0,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned STALL_TIMEOUT = 64
) (
    input logic           i_clk,
    input logic           i_reset,
    hazard_ctrl_if.slave  bus
);
    localparam int unsigned RUN_W = $clog2(STALL_TIMEOUT + 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_STALL    = 2'b01,
        ST_FLUSH    = 2'b10,
        ST_MEM_WAIT = 2'b11
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [RUN_W-1:0] run_cnt;
    logic             deadlock;

    logic [6:0] op_id;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic [4:0] rd_ex;
    logic [4:0] rd_mem;
    logic [4:0] rd_wb;
    logic       rs1_used;
    logic       rs2_used;
    logic       hit_a_ex, hit_a_mem, hit_a_wb;
    logic       hit_b_ex, hit_b_mem, hit_b_wb;
    logic       raw_hazard;
    logic [1:0] fwd_a_pick;
    logic [1:0] fwd_b_pick;

    logic       rst_pc, rst_if, rst_id, rst_ex, rst_mem;
    logic       en_pc, en_if, en_id, en_ex, en_mem;
    logic [1:0] fwd_a, fwd_b;

    logic       unused_bits;

    // A producer with rd == x0 never creates a dependency.
    function automatic logic src_hit(input logic used, input logic [4:0] rs,
                                     input logic wren, input logic [4:0] rd);
        return used && wren && (rd != 5'd0) && (rs == rd);
    endfunction

    // Youngest producer wins so the most recent value of the register is used.
    function automatic logic [1:0] pick_src(input logic ex, input logic mem, input logic wb);
        if (ex)       return 2'b01;
        else if (mem) return 2'b10;
        else if (wb)  return 2'b11;
        else          return 2'b00;
    endfunction

    assign op_id  = bus.instr_id[6:0];
    assign rs1_id = bus.instr_id[19:15];
    assign rs2_id = bus.instr_id[24:20];
    assign rd_ex  = bus.instr_ex[11:7];
    assign rd_mem = bus.instr_mem[11:7];
    assign rd_wb  = bus.instr_wb[11:7];

    assign unused_bits = ^{bus.instr_id[31:25], bus.instr_id[14:12],
                           bus.instr_ex[31:12], bus.instr_ex[6:0],
                           bus.instr_mem[31:12], bus.instr_mem[6:0],
                           bus.instr_wb[31:12], bus.instr_wb[6:0]};

    // Decode source-register usage of ID and detect RAW / forwarding sources.
    always_comb begin
        rs1_used  = !((op_id == OP_LUI) || (op_id == OP_AUIPC) || (op_id == OP_JAL));
        rs2_used  = (op_id == OP_RTYPE) || (op_id == OP_STORE) || (op_id == OP_BRANCH);
        hit_a_ex  = src_hit(rs1_used, rs1_id, bus.rd_wren_ex,  rd_ex);
        hit_a_mem = src_hit(rs1_used, rs1_id, bus.rd_wren_mem, rd_mem);
        hit_a_wb  = src_hit(rs1_used, rs1_id, bus.rd_wren_wb,  rd_wb);
        hit_b_ex  = src_hit(rs2_used, rs2_id, bus.rd_wren_ex,  rd_ex);
        hit_b_mem = src_hit(rs2_used, rs2_id, bus.rd_wren_mem, rd_mem);
        hit_b_wb  = src_hit(rs2_used, rs2_id, bus.rd_wren_wb,  rd_wb);
        raw_hazard = 1'b0;
        fwd_a_pick = 2'b00;
        fwd_b_pick = 2'b00;
        if (FWD_EN == 0) begin
            raw_hazard = hit_a_ex | hit_a_mem | hit_a_wb | hit_b_ex | hit_b_mem | hit_b_wb;
        end else begin
            raw_hazard = bus.mem_rd_ex && (hit_a_ex || hit_b_ex);
            fwd_a_pick = pick_src(hit_a_ex, hit_a_mem, hit_a_wb);
            fwd_b_pick = pick_src(hit_b_ex, hit_b_mem, hit_b_wb);
        end
    end

    // Prioritised stage controls; the action taken is also the next FSM state.
    always_comb begin
        rst_pc     = i_reset;
        rst_if     = i_reset;
        rst_id     = i_reset;
        rst_ex     = i_reset;
        rst_mem    = i_reset;
        en_pc      = 1'b1;
        en_if      = 1'b1;
        en_id      = 1'b1;
        en_ex      = 1'b1;
        en_mem     = 1'b1;
        fwd_a      = 2'b00;
        fwd_b      = 2'b00;
        next_state = ST_RUN;
        if (i_reset) begin
            fwd_a = fwd_a_pick;
            fwd_b = fwd_b_pick;
            if (bus.i_mem_stall) begin
                en_pc      = 1'b0;
                en_if      = 1'b0;
                en_id      = 1'b0;
                en_ex      = 1'b0;
                en_mem     = 1'b0;
                next_state = ST_MEM_WAIT;
            end else if (bus.pc_sel_ex) begin
                rst_if     = 1'b0;
                rst_id     = 1'b0;
                next_state = ST_FLUSH;
            end else if (raw_hazard) begin
                en_pc      = 1'b0;
                en_if      = 1'b0;
                en_id      = 1'b0;
                rst_ex     = 1'b0;
                next_state = ST_STALL;
            end else begin
                next_state = ST_RUN;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) state <= ST_RUN;
        else          state <= next_state;
    end

    // Saturating perf counters, consecutive-stall run length and sticky deadlock flag.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            run_cnt   <= '0;
            deadlock  <= 1'b0;
        end else begin
            if ((next_state == ST_STALL) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if ((next_state == ST_FLUSH) && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
            case (next_state)
                ST_STALL: begin
                    if (run_cnt < RUN_W'(STALL_TIMEOUT))
                        run_cnt <= run_cnt + RUN_W'(1);
                    if (run_cnt >= RUN_W'(STALL_TIMEOUT - 1))
                        deadlock <= 1'b1;
                end
                ST_MEM_WAIT: run_cnt <= run_cnt;
                default:     run_cnt <= '0;
            endcase
        end
    end

    assign bus.i_reset_pc        = rst_pc;
    assign bus.i_reset_if        = rst_if;
    assign bus.i_reset_id        = rst_id;
    assign bus.i_reset_ex        = rst_ex;
    assign bus.i_reset_mem       = rst_mem;
    assign bus.i_enable_pc       = en_pc;
    assign bus.i_enable_if       = en_if;
    assign bus.i_enable_id       = en_id;
    assign bus.i_enable_ex       = en_ex;
    assign bus.i_enable_mem      = en_mem;
    assign bus.o_fwd_a_sel       = fwd_a;
    assign bus.o_fwd_b_sel       = fwd_b;
    assign bus.o_state           = state;
    assign bus.o_stall_cnt       = stall_cnt;
    assign bus.o_flush_cnt       = flush_cnt;
    assign bus.o_deadlock        = deadlock;
    assign bus.data_hazard_debug = raw_hazard;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: three instances (no forwarding with a
// short watchdog, forwarding, narrow counters) share one stimulus stream.
module tb_hazard_ctrl_unit;
    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam logic [31:0] ADDI_X5      = 32'h0010_0293; // addi x5,x0,1
    localparam logic [31:0] ADDI_X0      = 32'h0010_0013; // addi x0,x0,1
    localparam logic [31:0] LW_X5        = 32'h0000_2283; // lw x5,0(x0)
    localparam logic [31:0] ADD_6_5_7    = 32'h0072_8333; // add x6,x5,x7
    localparam logic [31:0] ADD_6_5_5    = 32'h0052_8333; // add x6,x5,x5
    localparam logic [31:0] ADD_6_7_5    = 32'h0053_8333; // add x6,x7,x5
    localparam logic [31:0] ADD_6_0_7    = 32'h0070_0333; // add x6,x0,x7
    localparam logic [31:0] LUI_X6       = 32'h0002_8337; // lui x6,0x28 (bits 19:15 = 5)
    localparam logic [31:0] ADDI_6_1_5   = 32'h0050_8313; // addi x6,x1,5 (bits 24:20 = 5)

    // {rst pc,if,id,ex,mem, en pc,if,id,ex,mem}
    localparam logic [31:0] C_RUN   = 32'h3FF;
    localparam logic [31:0] C_RESET = 32'h01F;
    localparam logic [31:0] C_STALL = 32'h3A3;
    localparam logic [31:0] C_FLUSH = 32'h27F;
    localparam logic [31:0] C_MEMW  = 32'h3E0;

    localparam int unsigned F_CTRL = 0, F_FWD = 1, F_STATE = 2, F_SCNT = 3,
                            F_FCNT = 4, F_DL = 5, F_RAW = 6;

    typedef struct {
        string       tag;
        int unsigned dut;
        int unsigned fld;
        logic [31:0] exp;
    } exp_t;

    logic        i_clk;
    logic        i_reset;
    logic [31:0] instr_id, instr_ex, instr_mem, instr_wb;
    logic        rd_wren_ex, rd_wren_mem, rd_wren_wb;
    logic        mem_rd_ex, pc_sel_ex, i_mem_stall;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    exp_t        sb_q[$];

    hazard_ctrl_if #(.CNT_W(32)) if0 ();
    hazard_ctrl_if #(.CNT_W(32)) if1 ();
    hazard_ctrl_if #(.CNT_W(2))  if2 ();

    hazard_ctrl_unit #(.FWD_EN(0), .CNT_W(32), .STALL_TIMEOUT(8))  u_d0 (.i_clk(i_clk), .i_reset(i_reset), .bus(if0));
    hazard_ctrl_unit #(.FWD_EN(1), .CNT_W(32), .STALL_TIMEOUT(64)) u_d1 (.i_clk(i_clk), .i_reset(i_reset), .bus(if1));
    hazard_ctrl_unit #(.FWD_EN(0), .CNT_W(2),  .STALL_TIMEOUT(64)) u_d2 (.i_clk(i_clk), .i_reset(i_reset), .bus(if2));

    assign if0.instr_id = instr_id;  assign if0.instr_ex = instr_ex;
    assign if0.instr_mem = instr_mem; assign if0.instr_wb = instr_wb;
    assign if0.rd_wren_ex = rd_wren_ex; assign if0.rd_wren_mem = rd_wren_mem;
    assign if0.rd_wren_wb = rd_wren_wb; assign if0.mem_rd_ex = mem_rd_ex;
    assign if0.pc_sel_ex = pc_sel_ex; assign if0.i_mem_stall = i_mem_stall;

    assign if1.instr_id = instr_id;  assign if1.instr_ex = instr_ex;
    assign if1.instr_mem = instr_mem; assign if1.instr_wb = instr_wb;
    assign if1.rd_wren_ex = rd_wren_ex; assign if1.rd_wren_mem = rd_wren_mem;
    assign if1.rd_wren_wb = rd_wren_wb; assign if1.mem_rd_ex = mem_rd_ex;
    assign if1.pc_sel_ex = pc_sel_ex; assign if1.i_mem_stall = i_mem_stall;

    assign if2.instr_id = instr_id;  assign if2.instr_ex = instr_ex;
    assign if2.instr_mem = instr_mem; assign if2.instr_wb = instr_wb;
    assign if2.rd_wren_ex = rd_wren_ex; assign if2.rd_wren_mem = rd_wren_mem;
    assign if2.rd_wren_wb = rd_wren_wb; assign if2.mem_rd_ex = mem_rd_ex;
    assign if2.pc_sel_ex = pc_sel_ex; assign if2.i_mem_stall = i_mem_stall;

    logic [31:0] ctrl_v[3], fwd_v[3], st_v[3], sc_v[3], fc_v[3], dl_v[3], raw_v[3];

    assign ctrl_v[0] = 32'({if0.i_reset_pc, if0.i_reset_if, if0.i_reset_id, if0.i_reset_ex, if0.i_reset_mem,
                            if0.i_enable_pc, if0.i_enable_if, if0.i_enable_id, if0.i_enable_ex, if0.i_enable_mem});
    assign ctrl_v[1] = 32'({if1.i_reset_pc, if1.i_reset_if, if1.i_reset_id, if1.i_reset_ex, if1.i_reset_mem,
                            if1.i_enable_pc, if1.i_enable_if, if1.i_enable_id, if1.i_enable_ex, if1.i_enable_mem});
    assign ctrl_v[2] = 32'({if2.i_reset_pc, if2.i_reset_if, if2.i_reset_id, if2.i_reset_ex, if2.i_reset_mem,
                            if2.i_enable_pc, if2.i_enable_if, if2.i_enable_id, if2.i_enable_ex, if2.i_enable_mem});
    assign fwd_v[0] = 32'({if0.o_fwd_a_sel, if0.o_fwd_b_sel});
    assign fwd_v[1] = 32'({if1.o_fwd_a_sel, if1.o_fwd_b_sel});
    assign fwd_v[2] = 32'({if2.o_fwd_a_sel, if2.o_fwd_b_sel});
    assign st_v[0] = 32'(if0.o_state);  assign st_v[1] = 32'(if1.o_state);  assign st_v[2] = 32'(if2.o_state);
    assign sc_v[0] = if0.o_stall_cnt;   assign sc_v[1] = if1.o_stall_cnt;   assign sc_v[2] = 32'(if2.o_stall_cnt);
    assign fc_v[0] = if0.o_flush_cnt;   assign fc_v[1] = if1.o_flush_cnt;   assign fc_v[2] = 32'(if2.o_flush_cnt);
    assign dl_v[0] = 32'(if0.o_deadlock); assign dl_v[1] = 32'(if1.o_deadlock); assign dl_v[2] = 32'(if2.o_deadlock);
    assign raw_v[0] = 32'(if0.data_hazard_debug); assign raw_v[1] = 32'(if1.data_hazard_debug);
    assign raw_v[2] = 32'(if2.data_hazard_debug);

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Global time bound so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "time limit expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int unsigned d, input int unsigned f);
        case (f)
            F_CTRL:  return ctrl_v[d];
            F_FWD:   return fwd_v[d];
            F_STATE: return st_v[d];
            F_SCNT:  return sc_v[d];
            F_FCNT:  return fc_v[d];
            F_DL:    return dl_v[d];
            default: return raw_v[d];
        endcase
    endfunction

    task automatic push_exp(input string tag, input int unsigned d, input int unsigned f, input logic [31:0] v);
        sb_q.push_back('{tag: tag, dut: d, fld: f, exp: v});
    endtask

    task automatic next_cyc();
        @(negedge i_clk);
    endtask

    task automatic sample();
        exp_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val($sformatf("%s.d%0d", e.tag, e.dut), observe(e.dut, e.fld), e.exp);
        end
    endtask

    task automatic set_q();
        instr_id = NOP; instr_ex = NOP; instr_mem = NOP; instr_wb = NOP;
        rd_wren_ex = 1'b0; rd_wren_mem = 1'b0; rd_wren_wb = 1'b0;
        mem_rd_ex = 1'b0; pc_sel_ex = 1'b0; i_mem_stall = 1'b0;
    endtask

    task automatic set_raw();
        set_q();
        instr_ex = ADDI_X5; rd_wren_ex = 1'b1; instr_id = ADD_6_5_7;
    endtask

    initial begin
        i_reset = 1'b0;
        set_q();

        // reset with a live RAW: stage resets low, enables high, no forwarding
        next_cyc(); i_reset = 1'b0; set_raw();
        push_exp("rst_ctrl", 0, F_CTRL, C_RESET); push_exp("rst_ctrl", 1, F_CTRL, C_RESET);
        push_exp("rst_fwd", 1, F_FWD, 0);
        sample();
        next_cyc(); sample();
        next_cyc(); i_reset = 1'b1; set_q();
        for (int unsigned d = 0; d < 2; d++) begin
            push_exp("rst_state", d, F_STATE, 0); push_exp("rst_scnt", d, F_SCNT, 0);
            push_exp("rst_fcnt", d, F_FCNT, 0);   push_exp("rst_dl", d, F_DL, 0);
            push_exp("idle_ctrl", d, F_CTRL, C_RUN);
        end
        sample();

        // addi x5 marching EX->MEM->WB with add x6,x5,x7 in ID
        next_cyc(); set_raw();
        push_exp("t1c1_ctrl", 0, F_CTRL, C_STALL); push_exp("t1c1_raw", 0, F_RAW, 1);
        push_exp("t1c1_ctrl", 1, F_CTRL, C_RUN);   push_exp("t1c1_fwd", 1, F_FWD, 32'b0100);
        push_exp("t1c1_raw", 1, F_RAW, 0);
        sample();
        next_cyc(); set_q(); instr_id = ADD_6_5_7; instr_mem = ADDI_X5; rd_wren_mem = 1'b1;
        push_exp("t1c2_ctrl", 0, F_CTRL, C_STALL); push_exp("t1c2_state", 0, F_STATE, 1);
        push_exp("t1c2_scnt", 0, F_SCNT, 1);       push_exp("t1c2_fwd", 1, F_FWD, 32'b1000);
        sample();
        next_cyc(); set_q(); instr_id = ADD_6_5_7; instr_wb = ADDI_X5; rd_wren_wb = 1'b1;
        push_exp("t1c3_ctrl", 0, F_CTRL, C_STALL); push_exp("t1c3_scnt", 0, F_SCNT, 2);
        push_exp("t1c3_fwd", 1, F_FWD, 32'b1100);
        sample();
        next_cyc(); set_q();
        push_exp("t1c4_ctrl", 0, F_CTRL, C_RUN);  push_exp("t1c4_scnt", 0, F_SCNT, 3);
        push_exp("t1c4_state", 0, F_STATE, 1);    push_exp("t1c4_fwd", 1, F_FWD, 0);
        push_exp("t1c4_scnt", 1, F_SCNT, 0);      push_exp("t1c4_state", 1, F_STATE, 0);
        sample();
        next_cyc();
        push_exp("t1c5_state", 0, F_STATE, 0); push_exp("t1c5_scnt", 2, F_SCNT, 3);
        sample();

        // decode boundaries: unused source fields, no write enable, x0 producer
        next_cyc(); set_q(); instr_ex = ADDI_X5; rd_wren_ex = 1'b1; instr_id = LUI_X6;
        push_exp("lui_raw", 0, F_RAW, 0); push_exp("lui_ctrl", 0, F_CTRL, C_RUN);
        sample();
        next_cyc(); instr_id = ADDI_6_1_5;
        push_exp("itype_rs2_raw", 0, F_RAW, 0); push_exp("itype_rs2_fwd", 1, F_FWD, 0);
        sample();
        next_cyc(); instr_id = ADD_6_5_7; rd_wren_ex = 1'b0;
        push_exp("nowren_raw", 0, F_RAW, 0);
        sample();
        next_cyc(); instr_ex = ADDI_X0; rd_wren_ex = 1'b1; instr_id = ADD_6_0_7;
        push_exp("x0_raw", 0, F_RAW, 0); push_exp("x0_fwd", 1, F_FWD, 0);
        sample();
        next_cyc(); instr_ex = ADDI_X5; instr_id = ADD_6_7_5;
        push_exp("rs2_raw", 0, F_RAW, 1); push_exp("rs2_fwd", 1, F_FWD, 32'b0001);
        sample();

        // load-use with forwarding: one stall, then both operands from MEM
        next_cyc(); set_q(); instr_ex = LW_X5; rd_wren_ex = 1'b1; mem_rd_ex = 1'b1; instr_id = ADD_6_5_5;
        push_exp("lu1_ctrl", 1, F_CTRL, C_STALL); push_exp("lu1_raw", 1, F_RAW, 1);
        sample();
        next_cyc(); set_q(); instr_mem = LW_X5; rd_wren_mem = 1'b1; instr_id = ADD_6_5_5;
        push_exp("lu2_ctrl", 1, F_CTRL, C_RUN);    push_exp("lu2_fwd", 1, F_FWD, 32'b1010);
        push_exp("lu2_scnt", 1, F_SCNT, 1);        push_exp("lu2_state", 1, F_STATE, 1);
        push_exp("lu2_scnt", 0, F_SCNT, 5);        push_exp("sat_scnt", 2, F_SCNT, 3);
        push_exp("lu2_ctrl", 0, F_CTRL, C_STALL);
        sample();
        next_cyc(); set_q();
        push_exp("lu3_state", 1, F_STATE, 0); push_exp("lu3_scnt", 1, F_SCNT, 1);
        push_exp("lu3_scnt", 0, F_SCNT, 6);
        sample();

        // taken branch with RAW in ID: flush wins over the stall
        next_cyc(); set_raw(); pc_sel_ex = 1'b1;
        push_exp("fl1_ctrl", 0, F_CTRL, C_FLUSH); push_exp("fl1_ctrl", 1, F_CTRL, C_FLUSH);
        push_exp("fl1_raw", 0, F_RAW, 1);
        sample();
        next_cyc(); set_q();
        push_exp("fl2_state", 0, F_STATE, 2); push_exp("fl2_fcnt", 0, F_FCNT, 1);
        push_exp("fl2_fcnt", 1, F_FCNT, 1);   push_exp("fl2_scnt", 0, F_SCNT, 6);
        push_exp("fl2_ctrl", 0, F_CTRL, C_RUN);
        sample();
        next_cyc();
        push_exp("fl3_state", 0, F_STATE, 0); push_exp("fl3_fcnt", 0, F_FCNT, 1);
        sample();

        // memory wait for 5 cycles over a RAW: full freeze, stall count untouched
        for (int i = 0; i < 5; i++) begin
            next_cyc(); set_raw(); i_mem_stall = 1'b1;
            push_exp("mw_ctrl", 0, F_CTRL, C_MEMW); push_exp("mw_ctrl", 1, F_CTRL, C_MEMW);
            push_exp("mw_scnt", 0, F_SCNT, 6);
            if (i > 0) push_exp("mw_state", 0, F_STATE, 3);
            sample();
        end
        next_cyc(); set_q();
        push_exp("mw_exit_state", 0, F_STATE, 3); push_exp("mw_exit_ctrl", 0, F_CTRL, C_RUN);
        push_exp("mw_exit_scnt", 0, F_SCNT, 6);
        sample();
        next_cyc();
        push_exp("mw_run_state", 0, F_STATE, 0); push_exp("mw_run_state", 1, F_STATE, 0);
        sample();

        // watchdog: 8 stall cycles with a memory wait in the middle of the run
        for (int i = 1; i <= 9; i++) begin
            next_cyc(); set_raw(); i_mem_stall = (i == 5);
            if (i == 5) push_exp("dl_mw_ctrl", 0, F_CTRL, C_MEMW);
            if (i == 9) begin
                push_exp("dl_pre", 0, F_DL, 0); push_exp("dl_pre_state", 0, F_STATE, 1);
            end
            sample();
        end
        next_cyc(); set_q();
        push_exp("dl_set", 0, F_DL, 1);   push_exp("dl_scnt", 0, F_SCNT, 14);
        push_exp("dl_other", 1, F_DL, 0); push_exp("dl_other", 2, F_DL, 0);
        push_exp("dl_ctrl", 0, F_CTRL, C_RUN);
        sample();
        next_cyc(); set_raw();
        push_exp("dl_sticky", 0, F_DL, 1); push_exp("dl_stall_ctrl", 0, F_CTRL, C_STALL);
        sample();
        next_cyc(); i_reset = 1'b0; set_raw();
        push_exp("mid_rst_ctrl", 0, F_CTRL, C_RESET); push_exp("mid_rst_dl", 0, F_DL, 1);
        push_exp("mid_rst_state", 0, F_STATE, 1);     push_exp("mid_rst_scnt", 0, F_SCNT, 15);
        push_exp("mid_rst_fwd", 1, F_FWD, 0);
        sample();
        next_cyc(); i_reset = 1'b1; set_q();
        push_exp("post_rst_dl", 0, F_DL, 0);      push_exp("post_rst_scnt", 0, F_SCNT, 0);
        push_exp("post_rst_fcnt", 0, F_FCNT, 0);  push_exp("post_rst_state", 0, F_STATE, 0);
        push_exp("post_rst_fcnt", 1, F_FCNT, 0);  push_exp("post_rst_scnt", 2, F_SCNT, 0);
        sample();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
